// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed 7-segment scanner with hex decode, leading-zero
// blanking, PWM brightness and frame-synchronous input shadowing.
module seg7_scan #(
    parameter int DIGITS         = 8,
    parameter int PRESCALE       = 25000,
    parameter int BRIGHT_W       = 4,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   di,
    input  logic [8*DIGITS-1:0]   pixels,
    input  logic                  direct,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);

    localparam int PW = $clog2(PRESCALE);
    localparam int DW = $clog2(DIGITS);
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] DLAST = DW'(DIGITS - 1);
    localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] AN_OFF =
        AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [DIGITS-1:0] ONE = {{(DIGITS-1){1'b0}}, 1'b1};

    logic [PW-1:0]       pcnt_q, pcnt_d;
    logic [DW-1:0]       dig_q, dig_d;
    logic [BRIGHT_W-1:0] pwm_q, pwm_d;
    logic                first_q;

    logic [4*DIGITS-1:0] sh_di_q;
    logic [8*DIGITS-1:0] sh_pix_q;
    logic                sh_dir_q;
    logic [DIGITS-1:0]   sh_dp_q;
    logic                sh_blz_q;

    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_q, frame_d;

    logic                tick, wrap, load;
    logic [3:0]          nib;
    logic [6:0]          glyph;
    logic [DIGITS-1:0]   zero_from;
    logic                zero_hi;
    logic                blanked;
    logic                an_on;
    logic [7:0]          seg_hi;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] r;
        r = 7'h00;
        case (n)
            4'h0: r = 7'h3F;
            4'h1: r = 7'h06;
            4'h2: r = 7'h5B;
            4'h3: r = 7'h4F;
            4'h4: r = 7'h66;
            4'h5: r = 7'h6D;
            4'h6: r = 7'h7D;
            4'h7: r = 7'h07;
            4'h8: r = 7'h7F;
            4'h9: r = 7'h6F;
            4'hA: r = 7'h77;
            4'hB: r = 7'h7C;
            4'hC: r = 7'h39;
            4'hD: r = 7'h5E;
            4'hE: r = 7'h79;
            4'hF: r = 7'h71;
        endcase
        return r;
    endfunction

    assign tick = (pcnt_q == PLAST);
    assign wrap = tick && (dig_q == DLAST);
    // First clock after reset and every frame wrap refresh the shadows.
    assign load = first_q || wrap;

    always_comb begin
        pcnt_d = tick ? '0 : pcnt_q + PW'(1);
        dig_d  = dig_q;
        if (tick) begin
            dig_d = wrap ? '0 : dig_q + DW'(1);
        end
        pwm_d = pwm_q + BRIGHT_W'(1);
    end

    // zero_from[i]: nibbles DIGITS-1 down to i are all zero.
    always_comb begin
        zero_hi   = 1'b1;
        zero_from = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_hi      = zero_hi & (sh_di_q[4*i +: 4] == 4'h0);
            zero_from[i] = zero_hi;
        end
    end

    always_comb begin
        nib     = sh_di_q[{dig_q, 2'b00} +: 4];
        glyph   = hex7(nib);
        blanked = sh_blz_q && (dig_q != '0) && zero_from[dig_q];
        if (sh_dir_q) begin
            seg_hi = sh_pix_q[{dig_q, 3'b000} +: 8];
        end else begin
            seg_hi = {sh_dp_q[dig_q], blanked ? 7'h00 : glyph};
        end
        an_on   = (pcnt_q != '0) && (pwm_q <= brightness);
        seg_d   = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
        an_d    = AN_OFF;
        if (an_on) begin
            an_d = AN_ACTIVE_LOW ? ~(ONE << dig_q) : (ONE << dig_q);
        end
        frame_d = wrap;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q   <= '0;
            dig_q    <= '0;
            pwm_q    <= '0;
            first_q  <= 1'b1;
            sh_di_q  <= '0;
            sh_pix_q <= '0;
            sh_dir_q <= 1'b0;
            sh_dp_q  <= '0;
            sh_blz_q <= 1'b0;
            seg_q    <= SEG_OFF;
            an_q     <= AN_OFF;
            frame_q  <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            dig_q   <= dig_d;
            pwm_q   <= pwm_d;
            first_q <= 1'b0;
            if (load) begin
                sh_di_q  <= di;
                sh_pix_q <= pixels;
                sh_dir_q <= direct;
                sh_dp_q  <= dp;
                sh_blz_q <= blank_lz;
            end
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;

endmodule
